// File: rtl/cpu_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM state and grant owner encodings.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_D  = 2'd2,
        RESP     = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } arb_gnt_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port unified I/D memory between instruction fetch (IF) and the
// load/store unit (D). Each access walks IDLE -> GRANT_x -> RESP -> IDLE, the winner's
// payload is frozen at grant time, and read data comes back with a one-cycle ack.
// D has fixed priority; a saturating burst counter hands the port to IF after
// MAX_D_BURST consecutive D grants taken while IF was waiting.
//
// Handshakes: a requester raises x_req with its payload and holds it until x_ack,
// which is a single-cycle pulse with x_rdata valid in that cycle. Towards memory,
// mem_req is held together with a stable payload until the cycle mem_ready=1, which
// completes the access; mem_ready in any other cycle is ignored.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int n           = 32,
    parameter int AW          = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_ack,
    output logic [n-1:0]      if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [n-1:0]      d_wdata,
    input  logic [n/8-1:0]    d_be,
    output logic              d_ack,
    output logic [n-1:0]      d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [n-1:0]      mem_wdata,
    output logic [n/8-1:0]    mem_be,
    input  logic [n-1:0]      mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output arb_state_t        dbg_state
);

    localparam int BW = n / 8;
    localparam int CW = $clog2(MAX_D_BURST + 1);
    localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_D_BURST);

    arb_state_t     state;
    arb_gnt_t       gnt;
    logic [CW-1:0]  burst_cnt;
    logic           lat_we;
    logic [AW-1:0]  lat_addr;
    logic [n-1:0]   lat_wdata;
    logic [BW-1:0]  lat_be;
    logic           d_wins;

    // D takes the port unless IF has already been passed over MAX_D_BURST times in a row
    always_comb begin
        d_wins = d_req && (!if_req || (burst_cnt < BURST_LIMIT));
    end

    // Access sequencer: arbitration, payload freeze, read-data capture, starvation count
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= GNT_IF;
            burst_cnt <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        state     <= GRANT_D;
                        gnt       <= GNT_D;
                        lat_we    <= d_we;
                        lat_addr  <= d_addr;
                        lat_wdata <= d_wdata;
                        lat_be    <= d_be;
                        // Only grants that overtake a waiting IF count towards the burst
                        if (if_req) begin
                            burst_cnt <= (burst_cnt == BURST_LIMIT) ? BURST_LIMIT
                                                                    : burst_cnt + CW'(1);
                        end else begin
                            burst_cnt <= '0;
                        end
                    end else if (if_req) begin
                        state     <= GRANT_IF;
                        gnt       <= GNT_IF;
                        lat_we    <= 1'b0;
                        lat_addr  <= if_addr;
                        lat_wdata <= '0;
                        lat_be    <= '1;
                        burst_cnt <= '0;
                    end
                end
                GRANT_IF: begin
                    if (mem_ready) begin
                        if_rdata <= mem_rdata;
                        state    <= RESP;
                    end
                end
                GRANT_D: begin
                    if (mem_ready) begin
                        d_rdata <= mem_rdata;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory-side and status outputs decoded from the state and the frozen payload
    always_comb begin
        mem_req   = (state == GRANT_IF) || (state == GRANT_D);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (mem_req) begin
            mem_we    = lat_we;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_be    = lat_be;
        end
        if_ack    = (state == RESP) && (gnt == GNT_IF);
        d_ack     = (state == RESP) && (gnt == GNT_D);
        busy      = (state != IDLE);
        dbg_state = state;
    end

endmodule
